// File: rtl/ldpc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ldpc_pkg                                                                 |
// | Shared constants and sizing helpers for the QC-LDPC circulant shifter.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package ldpc_pkg;

    localparam logic c_DIR_FWD = 1'b0;
    localparam logic c_DIR_INV = 1'b1;

    function automatic int bus_w(input int data_w, input int d);
        return data_w * d;
    endfunction

    function automatic int lane_lo(input int data_w, input int k);
        return k * data_w;
    endfunction

    // All-ones shift field is the canonical null-submatrix encoding.
    function automatic int null_shift(input int shift_w);
        return (1 << shift_w) - 1;
    endfunction

    // Mux levels needed so that every effective shift e < d is reachable.
    function automatic int rot_levels(input int d);
        return (d <= 2) ? 1 : $clog2(d);
    endfunction

    function automatic int level_amt(input int j, input int d);
        return (1 << j) % d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/qc_rot_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | qc_rot_stage                                                             |
// | One barrel-rotator mux level with an optional valid/ready register slice.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module qc_rot_stage
    import ldpc_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int D       = 8,
    parameter int AMT     = 1,
    parameter int SEL_W   = 3,
    parameter int SEL_BIT = 0,
    parameter int TAG_W   = 4,
    parameter int REG     = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [DATA_W*D-1:0]    i_data,
    input  logic [SEL_W-1:0]       i_shift,
    input  logic                   i_null,
    input  logic [TAG_W-1:0]       i_tag,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [DATA_W*D-1:0]    o_data,
    output logic [SEL_W-1:0]       o_shift,
    output logic                   o_null,
    output logic [TAG_W-1:0]       o_tag
);

    localparam int c_BUS = bus_w(DATA_W, D);

    logic [c_BUS-1:0] w_rot;

    always_comb begin
        w_rot = i_data;
        if (i_shift[SEL_BIT]) begin
            for (int k = 0; k < D; k++) begin
                w_rot[lane_lo(DATA_W, k) +: DATA_W] =
                    i_data[lane_lo(DATA_W, (k + AMT) % D) +: DATA_W];
            end
        end
    end

    generate
        if (REG != 0) begin : g_reg
            logic               r_valid;
            logic [c_BUS-1:0]   r_data;
            logic [SEL_W-1:0]   r_shift;
            logic               r_null;
            logic [TAG_W-1:0]   r_tag;

            // Bubble-collapsing: load whenever empty or the successor drains us.
            assign o_ready = !r_valid || i_ready;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                    r_shift <= '0;
                    r_null  <= 1'b0;
                    r_tag   <= '0;
                end else if (o_ready) begin
                    r_valid <= i_valid;
                    if (i_valid) begin
                        r_data  <= w_rot;
                        r_shift <= i_shift;
                        r_null  <= i_null;
                        r_tag   <= i_tag;
                    end
                end
            end

            assign o_valid = r_valid;
            assign o_data  = r_data;
            assign o_shift = r_shift;
            assign o_null  = r_null;
            assign o_tag   = r_tag;
        end else begin : g_comb
            logic w_unused_clk;

            assign w_unused_clk = ^{clk, rst};
            assign o_ready = i_ready;
            assign o_valid = i_valid;
            assign o_data  = w_rot;
            assign o_shift = i_shift;
            assign o_null  = i_null;
            assign o_tag   = i_tag;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/qc_cyc_shift_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | qc_cyc_shift_pipe                                                        |
// | Runtime-programmable pipelined cyclic shifter for one QC-LDPC circulant. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module qc_cyc_shift_pipe
    import ldpc_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int D       = 8,
    parameter int SHIFT_W = $clog2(D),
    parameter int TAG_W   = 4,
    parameter int PIPE    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W*D-1:0]    in_data,
    input  logic [SHIFT_W-1:0]     in_shift,
    input  logic                   in_dir,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W*D-1:0]    out_data,
    output logic                   out_null,
    output logic [TAG_W-1:0]       out_tag
);

    localparam int c_BUS    = bus_w(DATA_W, D);
    localparam int c_LEVELS = rot_levels(D);

    logic                   w_null_in;
    logic [c_LEVELS-1:0]    w_eff;
    logic [c_BUS-1:0]       w_data_in;
    logic                   w_unused_shift;

    // Inverse becomes a forward rotation by D-s; null lanes are zeroed up front
    // so the mux levels only ever see a shift below D.
    always_comb begin
        w_null_in = (int'(in_shift) >= D);
        w_eff     = '0;
        w_data_in = '0;
        if (!w_null_in) begin
            w_data_in = in_data;
            if (in_dir == c_DIR_INV && in_shift != '0) begin
                w_eff = c_LEVELS'(D - int'(in_shift));
            end else begin
                w_eff = in_shift[c_LEVELS-1:0];
            end
        end
    end

    generate
        for (genvar j = 0; j < c_LEVELS; j++) begin : g_stage
            logic                   w_in_valid;
            logic                   w_in_ready;
            logic [c_BUS-1:0]       w_in_data;
            logic [c_LEVELS-1:0]    w_in_shift;
            logic                   w_in_null;
            logic [TAG_W-1:0]       w_in_tag;
            logic                   w_out_valid;
            logic                   w_out_ready;
            logic [c_BUS-1:0]       w_out_data;
            logic [c_LEVELS-1:0]    w_out_shift;
            logic                   w_out_null;
            logic [TAG_W-1:0]       w_out_tag;

            if (j == 0) begin : g_head
                assign w_in_valid = in_valid;
                assign w_in_data  = w_data_in;
                assign w_in_shift = w_eff;
                assign w_in_null  = w_null_in;
                assign w_in_tag   = in_tag;
            end else begin : g_link
                assign w_in_valid = g_stage[j-1].w_out_valid;
                assign w_in_data  = g_stage[j-1].w_out_data;
                assign w_in_shift = g_stage[j-1].w_out_shift;
                assign w_in_null  = g_stage[j-1].w_out_null;
                assign w_in_tag   = g_stage[j-1].w_out_tag;
            end

            if (j == c_LEVELS - 1) begin : g_tail
                assign w_out_ready = out_ready;
            end else begin : g_body
                assign w_out_ready = g_stage[j+1].w_in_ready;
            end

            // PIPE=0 keeps only the last level registered.
            qc_rot_stage #(
                .DATA_W  (DATA_W),
                .D       (D),
                .AMT     (level_amt(j, D)),
                .SEL_W   (c_LEVELS),
                .SEL_BIT (j),
                .TAG_W   (TAG_W),
                .REG     ((PIPE != 0 || j == c_LEVELS - 1) ? 1 : 0)
            ) u_stage (
                .clk     (clk),
                .rst     (rst),
                .i_valid (w_in_valid),
                .o_ready (w_in_ready),
                .i_data  (w_in_data),
                .i_shift (w_in_shift),
                .i_null  (w_in_null),
                .i_tag   (w_in_tag),
                .o_valid (w_out_valid),
                .i_ready (w_out_ready),
                .o_data  (w_out_data),
                .o_shift (w_out_shift),
                .o_null  (w_out_null),
                .o_tag   (w_out_tag)
            );
        end
    endgenerate

    assign in_ready       = g_stage[0].w_in_ready && !rst;
    assign out_valid      = g_stage[c_LEVELS-1].w_out_valid;
    assign out_data       = g_stage[c_LEVELS-1].w_out_data;
    assign out_null       = g_stage[c_LEVELS-1].w_out_null;
    assign out_tag        = g_stage[c_LEVELS-1].w_out_tag;
    assign w_unused_shift = ^g_stage[c_LEVELS-1].w_out_shift;

endmodule
`default_nettype wire

// File: tb/tb_qc_cyc_shift_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_qc_cyc_shift_pipe                                                     |
// | Scoreboarded bench: D=8 PIPE=1, D=8 PIPE=0 and D=5 PIPE=1 instances.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_qc_cyc_shift_pipe;

    typedef struct {
        logic [63:0] data;
        logic        nul;
        logic [3:0]  tag;
    } exp_t;

    localparam logic [63:0] c_PAT = 64'h0807060504030201;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  iv, idir, ordy;
    logic [63:0] id [2];
    logic [39:0] id5;
    logic [3:0]  is [3];
    logic [3:0]  it [3];

    logic        o_v0, o_v1, o_v2, o_r0, o_r1, o_r2, o_n0, o_n1, o_n2;
    logic [63:0] od0, od1;
    logic [39:0] od2;
    logic [3:0]  ot0, ot1, ot2;
    logic [2:0]  ov, irdy, onul;

    int          n_checks = 0;
    int          n_errors = 0;
    int          dd [3] = '{8, 8, 5};
    exp_t        q [3][$];
    logic [2:0]  held_v;
    logic [63:0] held_d [3];
    logic        held_n [3];
    logic [3:0]  held_t [3];
    int          last_hs [3];
    int          run_len [3];
    int          cyc = 0;
    bit          rnd = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign ov   = {o_v2, o_v1, o_v0};
    assign irdy = {o_r2, o_r1, o_r0};
    assign onul = {o_n2, o_n1, o_n0};

    qc_cyc_shift_pipe #(.DATA_W(8), .D(8), .SHIFT_W(4), .TAG_W(4), .PIPE(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(o_r0), .in_data(id[0]),
        .in_shift(is[0]), .in_dir(idir[0]), .in_tag(it[0]), .out_valid(o_v0),
        .out_ready(ordy[0]), .out_data(od0), .out_null(o_n0), .out_tag(ot0));

    qc_cyc_shift_pipe #(.DATA_W(8), .D(8), .SHIFT_W(4), .TAG_W(4), .PIPE(0)) u_p0 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(o_r1), .in_data(id[1]),
        .in_shift(is[1]), .in_dir(idir[1]), .in_tag(it[1]), .out_valid(o_v1),
        .out_ready(ordy[1]), .out_data(od1), .out_null(o_n1), .out_tag(ot1));

    qc_cyc_shift_pipe #(.DATA_W(8), .D(5), .SHIFT_W(4), .TAG_W(4), .PIPE(1)) u_d5 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(o_r2), .in_data(id5),
        .in_shift(is[2]), .in_dir(idir[2]), .in_tag(it[2]), .out_valid(o_v2),
        .out_ready(ordy[2]), .out_data(od2), .out_null(o_n2), .out_tag(ot2));

    // Reference: out lane k = in lane (k+s) or (k-s) mod D; s >= D is all-zero.
    function automatic logic [63:0] model(input logic [63:0] d, input int s, input bit dir,
                                          input int n, output logic nul);
        logic [63:0] r;
        int src;
        r   = '0;
        nul = (s >= n);
        if (!nul) begin
            for (int k = 0; k < n; k++) begin
                src = dir ? (k - s + n) % n : (k + s) % n;
                r[k*8 +: 8] = d[src*8 +: 8];
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] cur_od(input int i);
        return (i == 0) ? od0 : (i == 1) ? od1 : {24'h0, od2};
    endfunction

    function automatic logic [3:0] cur_ot(input int i);
        return (i == 0) ? ot0 : (i == 1) ? ot1 : ot2;
    endfunction

    function automatic logic [63:0] cur_id(input int i);
        return (i == 2) ? {24'h0, id5} : id[i];
    endfunction

    always @(negedge clk) begin
        exp_t e;
        logic mn;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                q[i].delete();
                held_v[i] = 1'b0;
            end else begin
                if (held_v[i]) begin
                    chk($sformatf("d%0d_hold_valid", i), {63'h0, ov[i]}, 64'h1);
                    chk($sformatf("d%0d_hold_data", i), cur_od(i), held_d[i]);
                    chk($sformatf("d%0d_hold_null", i), {63'h0, onul[i]}, {63'h0, held_n[i]});
                    chk($sformatf("d%0d_hold_tag", i), {60'h0, cur_ot(i)}, {60'h0, held_t[i]});
                end
                held_v[i] = 1'b0;
                if (ov[i] && ordy[i]) begin
                    chk($sformatf("d%0d_sb_nonempty", i), {63'h0, q[i].size() != 0}, 64'h1);
                    if (q[i].size() != 0) begin
                        e = q[i].pop_front();
                        chk($sformatf("d%0d_sb_data", i), cur_od(i), e.data);
                        chk($sformatf("d%0d_sb_null", i), {63'h0, onul[i]}, {63'h0, e.nul});
                        chk($sformatf("d%0d_sb_tag", i), {60'h0, cur_ot(i)}, {60'h0, e.tag});
                    end
                    run_len[i] = (last_hs[i] == cyc - 1) ? run_len[i] + 1 : 1;
                    last_hs[i] = cyc;
                end else if (ov[i]) begin
                    held_v[i] = 1'b1;
                    held_d[i] = cur_od(i);
                    held_n[i] = onul[i];
                    held_t[i] = cur_ot(i);
                end
                if (iv[i] && irdy[i]) begin
                    e.data = model(cur_id(i), int'(is[i]), idir[i], dd[i], mn);
                    e.nul  = mn;
                    e.tag  = it[i];
                    q[i].push_back(e);
                end
            end
        end
    end

    task automatic send(input int i, input logic [63:0] d, input logic [3:0] s, input bit dir,
                        input logic [3:0] tag, output int waits);
        bit acc;
        iv[i] = 1'b1;
        if (i == 2) id5 = d[39:0];
        else        id[i] = d;
        is[i] = s;  idir[i] = dir;  it[i] = tag;
        waits = 0;
        forever begin
            if (rnd) ordy[i] = ($urandom_range(3) != 0);
            @(negedge clk);
            acc = irdy[i];
            @(posedge clk); #1;
            if (acc) break;
            waits++;
            if (waits > 60) begin
                chk($sformatf("d%0d_accept_timeout", i), {63'h0, acc}, 64'h1);
                break;
            end
        end
        iv[i] = 1'b0;
    endtask

    task automatic lat_test(input int i, input logic [3:0] s, input bit dir, input logic [3:0] tag,
                            input int exp_lat, input logic [63:0] exp_d, input logic exp_n);
        int w, n;
        send(i, c_PAT, s, dir, tag, w);
        n = 1;
        while (!ov[i] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("d%0d_latency_s%0d", i, s), n, exp_lat);
        chk($sformatf("d%0d_lit_data_s%0d", i, s), cur_od(i), exp_d);
        chk($sformatf("d%0d_lit_null_s%0d", i, s), {63'h0, onul[i]}, {63'h0, exp_n});
        chk($sformatf("d%0d_lit_tag_s%0d", i, s), {60'h0, cur_ot(i)}, {60'h0, tag});
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        mn;
        int          w, k, bad;
        logic [63:0] sd [5];
        logic [3:0]  ss [5];
        bit          sdir [5];

        iv = '0; idir = '0; ordy = 3'b111; id5 = '0; held_v = '0;
        for (int i = 0; i < 3; i++) begin
            is[i] = '0; it[i] = '0; last_hs[i] = -10; run_len[i] = 0;
            if (i < 2) id[i] = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("d%0d_rst_in_ready", i), {63'h0, irdy[i]}, 64'h0);
            chk($sformatf("d%0d_rst_out_valid", i), {63'h0, ov[i]}, 64'h0);
            chk($sformatf("d%0d_rst_out_null", i), {63'h0, onul[i]}, 64'h0);
            chk($sformatf("d%0d_rst_out_tag", i), {60'h0, cur_ot(i)}, 64'h0);
            chk($sformatf("d%0d_rst_out_data", i), cur_od(i), 64'h0);
        end

        chk("model_fwd3", model(c_PAT, 3, 1'b0, 8, mn), 64'h0302010807060504);
        chk("model_inv3", model(c_PAT, 3, 1'b1, 8, mn), 64'h0504030201080706);
        chk("model_fwd5", model(c_PAT, 5, 1'b0, 8, mn), 64'h0504030201080706);
        void'(model(c_PAT, 8, 1'b0, 8, mn));
        chk("model_null8", {63'h0, mn}, 64'h1);

        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("d0_in_ready_after_rst", {63'h0, irdy[0]}, 64'h1);
        @(posedge clk); #1;

        lat_test(0, 4'd3,  1'b0, 4'h5, 3, 64'h0302010807060504, 1'b0);
        lat_test(0, 4'd3,  1'b1, 4'h6, 3, 64'h0504030201080706, 1'b0);
        lat_test(0, 4'd0,  1'b0, 4'h7, 3, c_PAT, 1'b0);
        lat_test(0, 4'd0,  1'b1, 4'h8, 3, c_PAT, 1'b0);
        lat_test(0, 4'd8,  1'b0, 4'h9, 3, 64'h0, 1'b1);
        lat_test(0, 4'd15, 1'b1, 4'hA, 3, 64'h0, 1'b1);
        lat_test(1, 4'd5,  1'b0, 4'h3, 1, 64'h0504030201080706, 1'b0);

        // Back-to-back burst, alternating direction.
        for (int s = 1; s <= 7; s++) begin
            send(0, {$urandom(), $urandom()}, 4'(s), (s % 2) == 0, 4'(s), w);
            chk($sformatf("b2b_accept_wait_s%0d", s), w, 0);
        end
        repeat (6) @(posedge clk);
        #1;
        chk("b2b_output_run", run_len[0], 7);

        // Stall: 5 offered while downstream blocks.
        ordy[0] = 1'b0;
        for (int j = 0; j < 5; j++) begin
            sd[j] = {$urandom(), $urandom()};
            ss[j] = 4'($urandom_range(9));
            sdir[j] = 1'($urandom_range(1));
        end
        k = 0;
        for (int c = 0; c < 10; c++) begin
            bit acc;
            iv[0] = 1'b1; id[0] = sd[k]; is[0] = ss[k]; idir[0] = sdir[k]; it[0] = 4'(k + 1);
            @(negedge clk);
            acc = irdy[0];
            @(posedge clk); #1;
            if (acc) k++;
        end
        iv[0] = 1'b0;
        chk("stall_accepted", k, 3);
        chk("stall_in_ready", {63'h0, irdy[0]}, 64'h0);
        ordy[0] = 1'b1;
        for (int j = k; j < 5; j++) send(0, sd[j], ss[j], sdir[j], 4'(j + 1), w);
        repeat (6) @(posedge clk);
        #1;
        chk("stall_drained", q[0].size(), 0);

        // Reset with transactions in flight.
        ordy[0] = 1'b0;
        for (int j = 0; j < 3; j++) send(0, {$urandom(), $urandom()}, 4'(j + 2), 1'b0, 4'hC, w);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_flush_valid", {63'h0, ov[0]}, 64'h0);
        rst = 1'b0;
        ordy[0] = 1'b1;
        bad = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ov[0]) bad++;
        end
        chk("rst_no_stale_output", bad, 0);

        // Randomised traffic with random downstream backpressure.
        rnd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            for (int t = 0; t < 40; t++) begin
                send(i, {$urandom(), $urandom()}, 4'($urandom_range(i == 0 ? 15 : 7)),
                     1'($urandom_range(1)), 4'($urandom_range(15)), w);
            end
        end
        rnd = 1'b0;
        ordy = 3'b111;
        repeat (10) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) chk($sformatf("d%0d_final_drained", i), q[i].size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
